ifu_pf_fetch: RTL and testbench
===============================

// Module: ifu_pf_fetch
// PURPOSE
//  Parametrised instruction-fetch front end with in-order prefetch buffer; replaces single-IR fetch.
//  Issues sequential fetch requests ahead of EXU; holds up to DEPTH returned instrs with their PCs.
//  Handles pipeline flush (redirect), discards in-flight responses, latches bus errors.
//  Sits between the ITCM/bus fetch port and the EXU decode stage.
// PARAMETERS
//  PC_W      32  fetch address width; bits [1:0] of every issued PC are 0
//  INSTR_W   32  instruction width
//  DEPTH     4   prefetch buffer entries; power of 2, 2..16
//  MAX_OUTS  2   max outstanding fetch requests; 1..DEPTH
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        reset, asynchronous, active-low
//  pc_rtvec       in   PC_W     reset vector, sampled while rst_n low
//  ifu_req_valid  out  1        fetch request valid
//  ifu_req_ready  in   1        bus accepts request
//  ifu_req_pc     out  PC_W     fetch address
//  ifu_rsp_valid  in   1        response valid; responses return in request order
//  ifu_rsp_ready  out  1        always 1
//  ifu_rsp_instr  in   INSTR_W  fetched instruction
//  ifu_rsp_err    in   1        bus error on this response
//  ifu_o_valid    out  1        buffer head valid to EXU
//  ifu_o_ready    in   1        EXU accepts head
//  ifu_o_ir       out  INSTR_W  head instruction
//  ifu_o_pc       out  PC_W     head PC
//  ifu_o_err      out  1        head carries fetch error (instr field = `INSTR_NOP)
//  pipe_flush_req in   1        redirect request
//  pipe_flush_pc  in   PC_W     redirect target ([1:0] forced to 0)
//  pipe_flush_ack out  1        always 1; flush taken in the cycle req is high
//  inspect_pc     out  PC_W     next fetch PC
// BEHAVIOUR
//  Reset: fetch_pc=pc_rtvec&~3, state=BOOT, buffer empty, outs=0, drop=0; all valid outs 0.
//  FSM: BOOT -> RUN after one cycle (no request in BOOT).
//       RUN -> ERR when an accepted (non-dropped) rsp has err=1; no further requests in ERR.
//       ERR -> RUN only on pipe_flush_req. Flush in any state goes to RUN (BOOT: stays BOOT).
//  Credit: req_valid = RUN & (outs < MAX_OUTS) & (count + outs < DEPTH) & ~pipe_flush_req.
//  Req handshake: fetch_pc += 4 (wraps modulo 2^PC_W); outs += 1.
//  Rsp: outs -= 1; if drop>0 then drop -= 1, discard; else push {instr,pc,err} into buffer.
//    Push PC from internal rsp_pc counter (advances +4 per kept rsp); err entry stores `INSTR_NOP.
//  Req and rsp same cycle: outs unchanged.
//  Output: ifu_o_* driven from buffer head combinationally; pop on ifu_o_valid & ifu_o_ready.
//  Push and pop same cycle when full: legal only because credit rule prevents overflow; assert.
//  Latency: request to ifu_o_valid = bus latency + 1 cycle (registered push).
//  Flush (highest priority): buffer cleared, fetch_pc=rsp_pc=target, drop=outs minus any rsp in
//    this cycle (+1 if a request also handshakes this cycle, which is then suppressed by the
//    req_valid gating, so never happens); ifu_o_valid=0 next cycle; head popped this cycle ignored.
//  Flush while drop>0: drop accumulates correctly; drop never exceeds MAX_OUTS.
//  No bubble injection: hazards are resolved in EXU via ifu_o_valid gating.
// CONFIGURATION
//  IFU_PF_PERF_EN defined: adds outputs perf_fetched[31:0] (kept rsps) and perf_dropped[31:0]
//    (discarded rsps); saturate at 0xFFFF_FFFF; reset to 0; not cleared by flush.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  defines.v: `INSTR_NOP, IFU state encodings (`IFU_ST_BOOT/RUN/ERR), PC alignment mask.
//  Sub-module ifu_pf_fifo: synchronous FIFO, width INSTR_W+PC_W+1, depth DEPTH,
//    push/pop/clear, count output, gnrl_dfflr storage.
// TESTING
//  Reset pc_rtvec=0x8000_0000, zero-latency bus, ready=1 -> o_pc 0x8000_0000,_0004,_0008 in order.
//  ifu_o_ready=0, DEPTH=4 -> exactly 4 entries buffered, req_valid stays 0, no overflow.
//  2 outstanding, flush to 0x100 -> both old rsps dropped, first o_pc=0x100.
//  Rsp err=1 at 0x8000_0008 -> o_err=1, o_ir=`INSTR_NOP, no reqs until flush to 0x200.
//  fetch_pc=0xFFFF_FFFC -> next req pc=0x0000_0000.
//  IFU_PF_PERF_EN: case 3 -> perf_dropped=2; undefined build compiles without perf ports.

Source files
------------

// File: rtl/ifu_pf_fetch_pkg.sv
// Shared constants and types for the prefetching instruction-fetch front end.
package ifu_pf_fetch_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_ST_BOOT = 2'd0,
        IFU_ST_RUN  = 2'd1,
        IFU_ST_ERR  = 2'd2
    } ifu_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ifu_pf_fetch_fifo.sv
// Synchronous prefetch FIFO with clear; clear beats push and pop.
module ifu_pf_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            assert (!(push && full && !pop));
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Load-enable storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wptr] <= din;
    end

endmodule

// File: rtl/ifu_pf_fetch.sv
// Instruction fetch with in-order prefetch buffer, flush and error latching.
// Define IFU_PF_PERF_EN to add the perf_fetched/perf_dropped counters.
module ifu_pf_fetch
    import ifu_pf_fetch_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int INSTR_W  = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_OUTS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    pc_rtvec,
    output logic               ifu_req_valid,
    input  logic               ifu_req_ready,
    output logic [PC_W-1:0]    ifu_req_pc,
    input  logic               ifu_rsp_valid,
    output logic               ifu_rsp_ready,
    input  logic [INSTR_W-1:0] ifu_rsp_instr,
    input  logic               ifu_rsp_err,
    output logic               ifu_o_valid,
    input  logic               ifu_o_ready,
    output logic [INSTR_W-1:0] ifu_o_ir,
    output logic [PC_W-1:0]    ifu_o_pc,
    output logic               ifu_o_err,
    input  logic               pipe_flush_req,
    input  logic [PC_W-1:0]    pipe_flush_pc,
    output logic               pipe_flush_ack,
`ifdef IFU_PF_PERF_EN
    output logic [PC_W-1:0]    inspect_pc,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_dropped
`else
    output logic [PC_W-1:0]    inspect_pc
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTS + 1);
    localparam int FW = INSTR_W + PC_W + 1;
    localparam logic [PC_W-1:0] ALIGN = ~PC_W'(3);

    ifu_state_e      state;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] rsp_pc;
    logic [OW-1:0]   outs;
    logic [OW-1:0]   drop;
    logic [OW-1:0]   outs_nxt;
    logic [CW-1:0]   count;
    logic            empty;
    logic            req_hs;
    logic            rsp_hs;
    logic            keep;
    logic            discard;
    logic [FW-1:0]   push_data;
    logic [FW-1:0]   head;
    logic [PC_W-1:0] flush_tgt;

    assign flush_tgt = pipe_flush_pc & ALIGN;

    // Credit covers both outstanding slots and free buffer space.
    assign ifu_req_valid = (state == IFU_ST_RUN)
                         & (outs < OW'(MAX_OUTS))
                         & (int'(count) + int'(outs) < DEPTH)
                         & ~pipe_flush_req;
    assign ifu_req_pc     = fetch_pc;
    assign ifu_rsp_ready  = 1'b1;
    assign pipe_flush_ack = 1'b1;
    assign inspect_pc     = fetch_pc;

    assign req_hs   = ifu_req_valid & ifu_req_ready;
    assign rsp_hs   = ifu_rsp_valid;
    assign keep     = rsp_hs & (drop == '0) & ~pipe_flush_req;
    assign discard  = rsp_hs & ~keep;
    assign outs_nxt = outs + OW'(req_hs) - OW'(rsp_hs);

    assign push_data = {ifu_rsp_err, rsp_pc,
                        ifu_rsp_err ? INSTR_W'(INSTR_NOP) : ifu_rsp_instr};

    ifu_pf_fifo #(
        .W     (FW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pipe_flush_req),
        .push  (keep),
        .din   (push_data),
        .pop   (ifu_o_valid & ifu_o_ready),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    assign ifu_o_valid = ~empty;
    assign ifu_o_err   = head[FW-1];
    assign ifu_o_pc    = head[INSTR_W +: PC_W];
    assign ifu_o_ir    = head[INSTR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IFU_ST_BOOT;
            fetch_pc <= pc_rtvec & ALIGN;
            rsp_pc   <= pc_rtvec & ALIGN;
            outs     <= '0;
            drop     <= '0;
        end else if (pipe_flush_req) begin
            // Everything still in flight belongs to the old stream.
            fetch_pc <= flush_tgt;
            rsp_pc   <= flush_tgt;
            outs     <= outs_nxt;
            drop     <= outs_nxt;
            if (state != IFU_ST_BOOT) state <= IFU_ST_RUN;
        end else begin
            if (req_hs)  fetch_pc <= fetch_pc + PC_W'(4);
            if (keep)    rsp_pc   <= rsp_pc + PC_W'(4);
            if (discard) drop     <= drop - OW'(1);
            outs <= outs_nxt;
            unique case (state)
                IFU_ST_BOOT: state <= IFU_ST_RUN;
                IFU_ST_RUN:  if (keep && ifu_rsp_err) state <= IFU_ST_ERR;
                default:     ;
            endcase
        end
    end

`ifdef IFU_PF_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (keep)    perf_fetched <= sat_inc(perf_fetched);
            if (discard) perf_dropped <= sat_inc(perf_dropped);
        end
    end
`endif

endmodule

// File: tb/tb_ifu_pf_fetch.sv
// Scoreboard bench for ifu_pf_fetch with an in-order bus model.
module tb_ifu_pf_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_rtvec = 32'h8000_0000;
    logic        ifu_req_valid;
    logic        ifu_req_ready = 1'b1;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid = 1'b0;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr = '0;
    logic        ifu_rsp_err = 1'b0;
    logic        ifu_o_valid;
    logic        ifu_o_ready = 1'b0;
    logic [31:0] ifu_o_ir;
    logic [31:0] ifu_o_pc;
    logic        ifu_o_err;
    logic        pipe_flush_req = 1'b0;
    logic [31:0] pipe_flush_pc = '0;
    logic        pipe_flush_ack;
    logic [31:0] inspect_pc;
`ifdef IFU_PF_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        int          due;
    } bus_t;

    exp_t        sb[$];
    bus_t        bq[$];
    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    int          cyc = 0;
    int          bus_lat = 0;
    logic        bus_hold = 1'b0;
    logic [31:0] err_pc = 32'hFFFF_FFFF;

    ifu_pf_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_rtvec       (pc_rtvec),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_pc     (ifu_req_pc),
        .ifu_rsp_valid  (ifu_rsp_valid),
        .ifu_rsp_ready  (ifu_rsp_ready),
        .ifu_rsp_instr  (ifu_rsp_instr),
        .ifu_rsp_err    (ifu_rsp_err),
        .ifu_o_valid    (ifu_o_valid),
        .ifu_o_ready    (ifu_o_ready),
        .ifu_o_ir       (ifu_o_ir),
        .ifu_o_pc       (ifu_o_pc),
        .ifu_o_err      (ifu_o_err),
        .pipe_flush_req (pipe_flush_req),
        .pipe_flush_pc  (pipe_flush_pc),
        .pipe_flush_ack (pipe_flush_ack),
`ifdef IFU_PF_PERF_EN
        .inspect_pc     (inspect_pc),
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`else
        .inspect_pc     (inspect_pc)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0F0F;
    endfunction

    // Bus: accepts at negedge+1 what will handshake at the next posedge.
    initial forever begin
        @(negedge clk);
        #1;
        cyc++;
        if (rst_n && ifu_req_valid && ifu_req_ready)
            bq.push_back('{pc: ifu_req_pc, due: cyc + bus_lat});
        if (!bus_hold && bq.size() > 0 && bq[0].due <= cyc) begin
            ifu_rsp_valid = 1'b1;
            ifu_rsp_instr = instr_of(bq[0].pc);
            ifu_rsp_err   = (bq[0].pc == err_pc);
            void'(bq.pop_front());
        end else begin
            ifu_rsp_valid = 1'b0;
            ifu_rsp_instr = '0;
            ifu_rsp_err   = 1'b0;
        end
    end

    // Monitor: a pop will occur at the next posedge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n && ifu_o_valid && ifu_o_ready && !pipe_flush_req) begin
            pops++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop: got pc=%h ir=%h err=%b, required none",
                         ifu_o_pc, ifu_o_ir, ifu_o_err);
            end else begin
                e = sb.pop_front();
                if (ifu_o_pc !== e.pc || ifu_o_ir !== e.ir || ifu_o_err !== e.err) begin
                    errors++;
                    $display("FAIL pop_%0d: got pc=%h ir=%h err=%b, required pc=%h ir=%h err=%b",
                             pops, ifu_o_pc, ifu_o_ir, ifu_o_err, e.pc, e.ir, e.err);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        logic [31:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            if (pc == err_pc) sb.push_back('{pc: pc, ir: NOP, err: 1'b1});
            else              sb.push_back('{pc: pc, ir: instr_of(pc), err: 1'b0});
            pc = pc + 32'd4;
        end
    endtask

    task automatic flush_to(input logic [31:0] pc, input int n);
        pipe_flush_req = 1'b1;
        pipe_flush_pc  = pc;
        sb.delete();
        expect_seq(pc, n);
        tick(1);
        pipe_flush_req = 1'b0;
    endtask

    task automatic wait_pops(input string name, input int n);
        int target;
        bit done;
        target = pops + n;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick(1);
            if (pops >= target) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pops, required %0d", name, pops, target);
        end
    endtask

    initial begin
        tick(3);
        #3;
        chk("rst_req_valid", 32'(ifu_req_valid), 32'd0);
        chk("rst_o_valid", 32'(ifu_o_valid), 32'd0);
        chk("rst_inspect_pc", inspect_pc, 32'h8000_0000);
        chk("rsp_ready", 32'(ifu_rsp_ready), 32'd1);
        expect_seq(32'h8000_0000, 16);
        tick(1);
        rst_n = 1'b1;
        ifu_o_ready = 1'b1;
        #3;
        chk("boot_no_req", 32'(ifu_req_valid), 32'd0);
        wait_pops("seq", 6);

        ifu_o_ready = 1'b0;
        flush_to(32'h0000_1000, 8);
        tick(12);
        #3;
        chk("full_req_valid", 32'(ifu_req_valid), 32'd0);
        chk("full_o_valid", 32'(ifu_o_valid), 32'd1);
        chk("full_head_pc", ifu_o_pc, 32'h0000_1000);
        chk("full_inspect_pc", inspect_pc, 32'h0000_1010);
        tick(1);
        ifu_o_ready = 1'b1;
        wait_pops("drain", 6);

        ifu_o_ready = 1'b0;
        bus_hold = 1'b1;
        flush_to(32'h0000_2000, 0);
        tick(6);
        #3;
        chk("outs_req_valid", 32'(ifu_req_valid), 32'd0);
        chk("outs_inspect_pc", inspect_pc, 32'h0000_2008);
        chk("outs_o_valid", 32'(ifu_o_valid), 32'd0);
        tick(1);
        flush_to(32'h0000_0100, 4);
        bus_hold = 1'b0;
        ifu_o_ready = 1'b1;
        wait_pops("drop", 4);
        ifu_o_ready = 1'b0;
`ifdef IFU_PF_PERF_EN
        #3;
        chk("perf_dropped", perf_dropped, 32'd2);
        tick(1);
`endif

        err_pc = 32'h8000_0008;
        flush_to(32'h8000_0000, 3);
        tick(10);
        #3;
        chk("err_req_valid", 32'(ifu_req_valid), 32'd0);
        chk("err_inspect_pc", inspect_pc, 32'h8000_000C);
        chk("err_o_valid", 32'(ifu_o_valid), 32'd1);
        tick(1);
        ifu_o_ready = 1'b1;
        wait_pops("err", 3);
        tick(5);
        #3;
        chk("err_stall_o_valid", 32'(ifu_o_valid), 32'd0);
        chk("err_stall_req", 32'(ifu_req_valid), 32'd0);
        tick(1);
        flush_to(32'h0000_0200, 2);
        wait_pops("recover", 2);
        ifu_o_ready = 1'b0;

        bus_lat = 2;
        flush_to(32'hFFFF_FFF8, 4);
        tick(15);
        #3;
        chk("wrap_inspect_pc", inspect_pc, 32'h0000_0008);
        chk("wrap_req_valid", 32'(ifu_req_valid), 32'd0);
        tick(1);
        ifu_o_ready = 1'b1;
        wait_pops("wrap", 4);
        ifu_o_ready = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
